// File: rtl/red_pitaya_filter_cfg_writer.sv
// Filter config writer: shadow/commit registers and a ramped set_filter
// sequencer that walks each stage's shift field one step per dwell.
module red_pitaya_filter_cfg_writer #(
  parameter int STAGES    = 4,
  parameter int SHIFTBITS = 4,
  parameter int DWELL     = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_ack,
  output logic [31:0] set_filter,
  output logic        busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [7:0] NS_MASK = 8'(8'hFF << SHIFTBITS);

  logic [31:0]   shadow;
  logic [31:0]   target;
  logic [1:0]    state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;

  logic sel_shd, sel_act, sel_ctl, sel_sts;
  logic do_imm, do_commit;
  logic [7:0] a_byte, t_byte;
  logic [31:0] rd_mux;

  logic unused_addr;
  assign unused_addr = ^sys_addr[1:0];

  assign sel_shd = (sys_addr[3:2] == 2'd0);
  assign sel_act = (sys_addr[3:2] == 2'd1);
  assign sel_ctl = (sys_addr[3:2] == 2'd2);
  assign sel_sts = (sys_addr[3:2] == 2'd3);

  assign do_imm    = sys_wen & sel_ctl & sys_wdata[1];
  assign do_commit = sys_wen & sel_ctl & sys_wdata[0]
                   & ~sys_wdata[1];

  assign busy_o = (state != IDLE);
  assign a_byte = set_filter[{idx, 3'b000} +: 8];
  assign t_byte = target[{idx, 3'b000} +: 8];

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_shd: rd_mux = shadow;
      sel_act: rd_mux = set_filter;
      sel_ctl: rd_mux = '0;
      sel_sts: rd_mux = {31'd0, busy_o};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
      shadow    <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : 32'd0;
      if (sys_wen && sel_shd)
        shadow <= sys_wdata;
    end
  end

  // Bus commands pre-empt whatever the sequencer would do this cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      target     <= '0;
      set_filter <= '0;
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
    end else if (do_imm) begin
      set_filter <= shadow;
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
    end else if (do_commit) begin
      target <= shadow;
      for (int b = 0; b < 4; b++)
        if (b >= STAGES)
          set_filter[b*8 +: 8] <= shadow[b*8 +: 8];
      state <= STEP;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        STEP: begin
          if (((a_byte ^ t_byte) & NS_MASK) != 8'd0) begin
            set_filter[{idx, 3'b000} +: 8] <=
              (t_byte & NS_MASK) | (a_byte & ~NS_MASK);
            state <= WAIT;
            cnt   <= CW'(DWELL);
          end else if (a_byte != t_byte) begin
            // non-shift bits match, so whole-byte +-1 stays in field
            set_filter[{idx, 3'b000} +: 8] <=
              (a_byte < t_byte) ? a_byte + 8'd1 : a_byte - 8'd1;
            state <= WAIT;
            cnt   <= CW'(DWELL);
          end else if (idx == 2'(STAGES - 1)) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= STEP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/red_pitaya_filter_cfg_writer.md
Name: red_pitaya_filter_cfg_writer

Overview:
- Register-bus writer that generates the 32-bit `set_filter` configuration word consumed by the cascaded low/high-pass filter block.
- Software writes a target word to a shadow register and then commits it.
- The block ramps each stage's shift field one step at a time, with a programmable dwell between steps, so bandwidth changes do not cause output transients.
- An immediate mode bypasses the ramp.

Parameters:
- STAGES, 4, number of filter stages (bytes) the ramp sequencer walks; max 4.
- SHIFTBITS, 4, width of the shift field in each stage byte (bits [SHIFTBITS-1:0]).
- DWELL, 1024, clock cycles waited after each ramp write; must be ≥1.

Ports:
- clk_i, input, 1, system clock.
- rstn_i, input, 1, reset; asynchronous, active-low.
- sys_addr, input, 4, byte address; bits [3:2] select the register.
- sys_wdata, input, 32, write data.
- sys_wen, input, 1, write strobe, one cycle.
- sys_ren, input, 1, read strobe, one cycle.
- sys_rdata, output, 32, read data, valid while sys_ack is high.
- sys_ack, output, 1, one-cycle acknowledge.
- set_filter, output, 32, active configuration word to the filter block; registered.
- busy_o, output, 1, high while the ramp sequencer is not IDLE.

Behaviour:
- Reset (async on rstn_i low): shadow=0, target=0, set_filter=0, sys_rdata=0, sys_ack=0, busy_o=0, FSM=IDLE, stage index=0, dwell counter=0.
- Register map:
  - 0x0 SHADOW: RW.
  - 0x4 ACTIVE: RO, returns set_filter.
  - 0x8 CTRL: write-only. bit0=commit, bit1=immediate; reads 0.
  - 0xC STATUS: RO. bit0=busy_o.
  - Writes to RO addresses are ignored.
- Bus timing: sys_ack is asserted exactly 1 cycle after sys_wen or sys_ren, and sys_rdata is registered in the same cycle. A write takes effect on the cycle of sys_ack.
- Immediate (CTRL bit1 written):
  - Next cycle: set_filter ← SHADOW, FSM ← IDLE, busy_o ← 0.
  - Aborts any ramp in progress.
  - If bits 0 and 1 are written together, immediate wins.
- Commit (CTRL bit0, bit1=0):
  - target ← SHADOW.
  - set_filter bytes with index ≥ STAGES ← target bytes immediately.
  - FSM ← STEP with stage index j=0.
  - A commit while busy restarts at j=0 with the new target and continues from the current set_filter; no jump.
- FSM:
  - IDLE: busy_o=0.
  - STEP, one cycle, comparing byte j of set_filter (A) with byte j of target (T), in this priority order:
    - Non-shift bits [7:SHIFTBITS] differ: write them into A, keep A's shift, go to WAIT.
    - Else shift fields differ: A.shift ± 1 toward T.shift, go to WAIT.
    - Else equal: j ← j+1. If j == STAGES-1 was the last stage, go to IDLE; else stay in STEP.
  - WAIT: counter loads DWELL on entry and decrements each cycle. After DWELL cycles in WAIT, return to STEP at the same j.
- Shift arithmetic: unsigned, no wrap; the ±1 step never crosses T.shift.
- Cost per stage:
  - Each write costs 1+DWELL cycles.
  - Each equal stage check costs 1 cycle.
  - A stage already equal on entry costs exactly 1 cycle.
- busy_o: high from the cycle after the commit write is accepted through the last STEP cycle; low in IDLE.
- SHADOW writes during a ramp do not affect target until the next commit.

Test Plan:
- Reset release → set_filter=0, busy_o=0. Read 0x4 → sys_ack 1 cycle after sys_ren, sys_rdata=0.
- STAGES=2, DWELL=4, set_filter=0. Write SHADOW=0x00000083, then commit. Required response:
  - byte0 sequence 0x80, 0x81, 0x82, 0x83, with changes 5 cycles apart.
  - busy_o high for exactly 22 cycles.
  - Final set_filter=0x00000083.
- Ramp down: from 0x8F write SHADOW=0x8C and commit → byte0 sequence 0x8E, 0x8D, 0x8C; busy_o high 17 cycles.
- Mid-ramp commit: during the 0x80→0x83 ramp, when byte0=0x81, commit target 0x80 → next write 0x80, no jump to 0x83.
- Immediate mid-ramp: write CTRL=0x3 while busy → set_filter equals SHADOW the next cycle; busy_o=0; no further changes.
- Bytes beyond STAGES: STAGES=2, commit SHADOW=0xAB000000 → byte3=0xAB on the cycle after the commit, while bytes 0 and 1 are unchanged.
